// File: rtl/jt6295_pkg.sv
// Shared encodings and command-byte field positions for the JT6295 phrase controller.
package jt6295_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LOAD  = 2'd2
   } state_e;

   localparam int TBL_BYTES     = 6;
   localparam int CMD_START_BIT = 7;
   localparam int STOP_LSB      = 3;
   localparam int MASK_LSB      = 4;

endpackage

// File: rtl/jt6295_reqfifo.sv
// Small synchronous FIFO for queued start requests; a push is accepted when full
// only if a pop happens in the same cycle.
module jt6295_reqfifo #(
   parameter int QD = 2,
   parameter int W  = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int PW = (QD > 1) ? $clog2(QD) : 1;
   localparam int CW = $clog2(QD + 1);

   logic [W-1:0]  mem_q [QD];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CW'(QD));
   assign empty   = (count_q == '0);
   assign do_push = push && (!full || pop);
   assign rdata   = mem_q[rd_ptr_q];

   // NOTE: storage has no reset; the count and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/jt6295_ctrl_q.sv
// JT6295 command decoder and phrase-table fetcher: decodes CPU start/stop writes,
// queues start requests and reads each 6-byte table entry before strobing channels.
module jt6295_ctrl_q
   import jt6295_pkg::*;
#(
   parameter int CH  = 4,
   parameter int AW  = 18,
   parameter int QD  = 2,
   parameter int PHW = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wrn,
   input  logic [7:0]     din,
   output logic [PHW+2:0] rom_addr,
   output logic           rom_cs,
   input  logic [7:0]     rom_data,
   input  logic           rom_ok,
   input  logic [CH-1:0]  busy,
   output logic [CH-1:0]  start,
   output logic [CH-1:0]  stop,
   output logic [AW-1:0]  start_addr,
   output logic [AW-1:0]  stop_addr,
   output logic [3:0]     att,
   output logic           ovf
);

   localparam int FW = PHW + CH + 4;

   logic            last_wrn_q, wr_ev;
   logic            byte2_q;
   logic [PHW-1:0]  phrase_q;
   logic            push_q;
   logic [FW-1:0]   push_data_q;
   logic [CH-1:0]   stop_q;
   logic            ovf_q;
   logic [CH-1:0]   cmd_mask;

   logic            fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]   fifo_rdata;

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic            settle_q, settle_d;
   logic            rom_cs_q, rom_cs_d;
   logic [PHW-1:0]  cur_phrase_q, cur_phrase_d;
   logic [CH-1:0]   cur_mask_q, cur_mask_d;
   logic [3:0]      cur_att_q, cur_att_d;
   logic [AW-1:0]   start_acc_q, start_acc_d;
   logic [AW-1:0]   stop_acc_q, stop_acc_d;
   logic [CH-1:0]   start_q, start_d;
   logic [AW-1:0]   start_addr_q, start_addr_d;
   logic [AW-1:0]   stop_addr_q, stop_addr_d;
   logic [3:0]      att_q, att_d;

   assign wr_ev    = wrn & ~last_wrn_q;
   assign cmd_mask = din[MASK_LSB +: CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         last_wrn_q  <= 1'b1;
         byte2_q     <= 1'b0;
         phrase_q    <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         stop_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         last_wrn_q <= wrn;
         push_q     <= 1'b0;
         stop_q     <= '0;
         if (push_q && fifo_full && !fifo_pop) ovf_q <= 1'b1;
         if (wr_ev) begin
            if (byte2_q) begin
               byte2_q     <= 1'b0;
               push_q      <= (cmd_mask != '0);
               push_data_q <= {phrase_q, cmd_mask, din[3:0]};
            end else if (din[CMD_START_BIT]) begin
               phrase_q <= din[PHW-1:0];
               byte2_q  <= 1'b1;
            end else begin
               stop_q <= din[STOP_LSB +: CH];
            end
         end
      end
   end

   jt6295_reqfifo #(
      .QD (QD),
      .W  (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .wdata (push_data_q),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         settle_q     <= 1'b0;
         rom_cs_q     <= 1'b0;
         cur_phrase_q <= '0;
         cur_mask_q   <= '0;
         cur_att_q    <= '0;
         start_acc_q  <= '0;
         stop_acc_q   <= '0;
         start_q      <= '0;
         start_addr_q <= '0;
         stop_addr_q  <= '0;
         att_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         settle_q     <= settle_d;
         rom_cs_q     <= rom_cs_d;
         cur_phrase_q <= cur_phrase_d;
         cur_mask_q   <= cur_mask_d;
         cur_att_q    <= cur_att_d;
         start_acc_q  <= start_acc_d;
         stop_acc_q   <= stop_acc_d;
         start_q      <= start_d;
         start_addr_q <= start_addr_d;
         stop_addr_q  <= stop_addr_d;
         att_q        <= att_d;
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      settle_d     = settle_q;
      rom_cs_d     = rom_cs_q;
      cur_phrase_d = cur_phrase_q;
      cur_mask_d   = cur_mask_q;
      cur_att_d    = cur_att_q;
      start_acc_d  = start_acc_q;
      stop_acc_d   = stop_acc_q;
      start_d      = '0;
      start_addr_d = start_addr_q;
      stop_addr_d  = stop_addr_q;
      att_d        = att_q;
      fifo_pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               cur_phrase_d = fifo_rdata[FW-1 -: PHW];
               cur_mask_d   = fifo_rdata[4 +: CH];
               cur_att_d    = fifo_rdata[3:0];
               idx_d        = '0;
               settle_d     = 1'b1;
               rom_cs_d     = 1'b1;
               state_d      = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (settle_q) begin
               settle_d = 1'b0;
            end else if (rom_ok) begin
               // Shifting three bytes in keeps exactly the low AW bits of the 24-bit address.
               if (idx_q < 3'd3) start_acc_d = {start_acc_q[AW-9:0], rom_data};
               else              stop_acc_d  = {stop_acc_q[AW-9:0], rom_data};
               settle_d = 1'b1;
               if (idx_q == 3'(TBL_BYTES - 1)) state_d = ST_LOAD;
               else                            idx_d   = idx_q + 1'b1;
            end
         end
         ST_LOAD: begin
            start_d      = cur_mask_q & ~busy;
            start_addr_d = start_acc_q;
            stop_addr_d  = stop_acc_q;
            att_d        = cur_att_q;
            rom_cs_d     = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rom_addr   = {cur_phrase_q, idx_q};
   assign rom_cs     = rom_cs_q;
   assign start      = start_q;
   assign stop       = stop_q;
   assign start_addr = start_addr_q;
   assign stop_addr  = stop_addr_q;
   assign att        = att_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_jt6295_ctrl_q.sv
// Directed bench for jt6295_ctrl_q: a default (AW=18) instance and an AW=24 instance
// share stimulus and a byte-wide table ROM model.
module tb_jt6295_ctrl_q;

   logic       clk = 1'b0;
   logic       rst, wrn, rom_ok;
   logic [7:0] din;
   logic [3:0] busy;

   logic [9:0]  rom_addr, rom_addr24;
   logic        rom_cs, rom_cs24;
   logic [7:0]  rom_data, rom_data24;
   logic [3:0]  start, stop, start24, stop24, att, att24;
   logic [17:0] start_addr, stop_addr;
   logic [23:0] start_addr24, stop_addr24;
   logic        ovf, ovf24;

   logic [7:0] rom [0:1023];
   assign rom_data   = rom[rom_addr];
   assign rom_data24 = rom[rom_addr24];

   int checks = 0, failures = 0, cyc = 0;
   bit slow = 1'b0;

   always #5 clk = ~clk;

   jt6295_ctrl_q u_dut (
      .clk(clk), .rst(rst), .wrn(wrn), .din(din),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
      .busy(busy), .start(start), .stop(stop),
      .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .ovf(ovf)
   );

   jt6295_ctrl_q #(.AW(24)) u_dut24 (
      .clk(clk), .rst(rst), .wrn(wrn), .din(din),
      .rom_addr(rom_addr24), .rom_cs(rom_cs24), .rom_data(rom_data24), .rom_ok(rom_ok),
      .busy(busy), .start(start24), .stop(stop24),
      .start_addr(start_addr24), .stop_addr(stop_addr24), .att(att24), .ovf(ovf24)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      rom_ok = slow ? (cyc % 4 == 0) : 1'b1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      din = b;
      wrn = 1'b0;
      step();
      wrn = 1'b1;
      step();
   endtask

   task automatic set_entry(input int p, input logic [47:0] e);
      for (int i = 0; i < 6; i++) rom[p*8 + i] = e[47 - 8*i -: 8];
   endtask

   task automatic wait_start(output int n, output int cs_n, output logic [9:0] a0);
      n = 0;
      cs_n = -1;
      a0 = '0;
      while (start == '0 && n < 100) begin
         step();
         n++;
         if (cs_n < 0 && rom_cs) begin
            cs_n = n;
            a0 = rom_addr;
         end
      end
      chk("start_seen", 32'(start != '0), 32'd1);
   endtask

   initial begin
      int n, cs_n, hits;
      logic [9:0] a0;

      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      set_entry(1, 48'h000011_000019);
      set_entry(2, 48'h000021_000029);
      set_entry(3, 48'h001234_005678);
      set_entry(4, 48'h000041_000049);
      set_entry(5, 48'h000051_000059);
      set_entry(6, 48'hABCDEF_123456);

      rst = 1'b1; wrn = 1'b1; din = 8'h00; busy = 4'h0; rom_ok = 1'b1;
      repeat (3) step();
      chk("rst_start",      32'(start),      32'h0);
      chk("rst_stop",       32'(stop),       32'h0);
      chk("rst_rom_cs",     32'(rom_cs),     32'h0);
      chk("rst_start_addr", 32'(start_addr), 32'h0);
      chk("rst_stop_addr",  32'(stop_addr),  32'h0);
      chk("rst_att",        32'(att),        32'h0);
      chk("rst_ovf",        32'(ovf),        32'h0);
      rst = 1'b0;
      step();

      // Basic start: phrase 3, channel 0, att 4.
      wr_byte(8'h83);
      wr_byte(8'h14);
      wait_start(n, cs_n, a0);
      chk("t1_cs_rise",    32'(cs_n),       32'd2);
      chk("t1_latency",    32'(n),          32'd15);
      chk("t1_first_addr", 32'(a0),         32'h018);
      chk("t1_start",      32'(start),      32'h1);
      chk("t1_start_addr", 32'(start_addr), 32'h01234);
      chk("t1_stop_addr",  32'(stop_addr),  32'h05678);
      chk("t1_att",        32'(att),        32'h4);
      step();
      chk("t1_start_pulse", 32'(start),  32'h0);
      chk("t1_cs_low",      32'(rom_cs), 32'h0);

      // Stop all channels.
      wr_byte(8'h78);
      chk("t2_stop",    32'(stop),   32'hF);
      chk("t2_no_rom",  32'(rom_cs), 32'h0);
      step();
      chk("t2_stop_pulse", 32'(stop), 32'h0);
      hits = 0;
      repeat (5) begin
         step();
         if (rom_cs || start != '0) hits++;
      end
      chk("t2_no_fetch", 32'(hits), 32'd0);

      // Busy channel is not restarted.
      busy = 4'b0010;
      wr_byte(8'h83);
      wr_byte(8'h37);
      wait_start(n, cs_n, a0);
      chk("t4_start", 32'(start), 32'h1);
      chk("t4_att",   32'(att),   32'h7);
      step();
      busy = 4'h0;

      // Overflow: A fetched slowly while B, C, D arrive; D is dropped.
      slow = 1'b1;
      wr_byte(8'h81);
      wr_byte(8'h11);
      n = 0;
      while (!rom_cs && n < 20) begin
         step();
         n++;
      end
      chk("t3_fetch_began", 32'(rom_cs), 32'h1);
      wr_byte(8'h82); wr_byte(8'h22);
      wr_byte(8'h84); wr_byte(8'h43);
      wr_byte(8'h85); wr_byte(8'h84);
      step(); step();
      chk("t3_ovf", 32'(ovf), 32'h1);
      wait_start(n, cs_n, a0);
      chk("t3_a_start", 32'(start),      32'h1);
      chk("t3_a_addr",  32'(start_addr), 32'h00011);
      step();
      wait_start(n, cs_n, a0);
      chk("t3_b_start", 32'(start),      32'h2);
      chk("t3_b_addr",  32'(start_addr), 32'h00021);
      chk("t3_b_att",   32'(att),        32'h2);
      step();
      wait_start(n, cs_n, a0);
      chk("t3_c_start", 32'(start),      32'h4);
      chk("t3_c_addr",  32'(start_addr), 32'h00041);
      step();
      hits = 0;
      repeat (60) begin
         step();
         if (start != '0) hits++;
      end
      chk("t3_d_dropped", 32'(hits), 32'd0);
      slow = 1'b0;

      // Address truncation: AW=18 versus AW=24.
      wr_byte(8'h86);
      wr_byte(8'h1F);
      wait_start(n, cs_n, a0);
      chk("t5_start_addr18", 32'(start_addr),   32'h3CDEF);
      chk("t5_stop_addr18",  32'(stop_addr),    32'h23456);
      chk("t5_start_addr24", 32'(start_addr24), 32'hABCDEF);
      chk("t5_stop_addr24",  32'(stop_addr24),  32'h123456);
      chk("t5_att",          32'(att),          32'hF);
      step();

      // Reset in the middle of a fetch.
      wr_byte(8'h83);
      wr_byte(8'h11);
      n = 0;
      while (!(rom_cs && rom_addr[2:0] == 3'd3) && n < 40) begin
         step();
         n++;
      end
      chk("t6_reached_idx3", 32'(rom_addr), 32'h01B);
      rst = 1'b1;
      step();
      chk("t6_rst_cs",    32'(rom_cs), 32'h0);
      chk("t6_rst_start", 32'(start),  32'h0);
      chk("t6_rst_ovf",   32'(ovf),    32'h0);
      rst = 1'b0;
      hits = 0;
      repeat (30) begin
         step();
         if (rom_cs || start != '0) hits++;
      end
      chk("t6_fifo_empty", 32'(hits), 32'd0);
      wr_byte(8'h83);
      wr_byte(8'h12);
      wait_start(n, cs_n, a0);
      chk("t6_first_addr", 32'(a0),         32'h018);
      chk("t6_start",      32'(start),      32'h1);
      chk("t6_start_addr", 32'(start_addr), 32'h01234);
      chk("t6_att",        32'(att),        32'h2);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jt6295_ctrl_q.md
Name: jt6295_ctrl_q

Overview:
- Parametrised command decoder and phrase-table fetcher for the JT6295 ADPCM core. It is the successor to the single-slot controller.
- Decodes the 2-byte CPU start command and the 1-byte stop command.
- Queues start requests in a small FIFO and reads the 6-byte phrase entry (start/stop address) from ROM.
- Issues one-cycle per-channel load strobes, carrying address and attenuation, to the channel engines.

Parameters:
CH, 4, number of voice channels (1..4); the command mask bits at CH and above are ignored.
AW, 18, sample address width (18..24); each table address is 3 bytes, and bits at AW and above are discarded.
QD, 2, start-request FIFO depth (1..4).
PHW, 7, phrase index width; the table holds 2^PHW entries of 8 bytes.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wrn  in  1  CPU write strobe, active-low; a write is taken on its rising edge, sampled in clk
din  in  8  CPU data bus
rom_addr  out  PHW+3  table byte address {phrase, byte_idx}
rom_cs  out  1  table ROM chip select
rom_data  in  8  table ROM data
rom_ok  in  1  rom_data valid for the current rom_addr
busy  in  CH  channel playing flags
start  out  CH  one-cycle load strobe per channel
stop  out  CH  one-cycle stop strobe per channel
start_addr  out  AW  phrase start address, valid while start!=0
stop_addr  out  AW  phrase stop address, valid while start!=0
att  out  4  attenuation, valid while start!=0
ovf  out  1  sticky: a start request was dropped because the FIFO was full

Behaviour:
- Reset: start=0, stop=0, rom_cs=0, start_addr=0, stop_addr=0, att=0, ovf=0. The FIFO is emptied, the decoder returns to byte 1 and the FSM goes to IDLE. A reset mid-fetch aborts the fetch; no strobe follows.
- Write edge detect: wr_ev = wrn & ~last_wrn. last_wrn is reset to 1, so a write is detected from a low-to-high transition only.
- Decoder, byte 1, din[7]=1: latch phrase=din[PHW-1:0] and expect byte 2.
- Decoder, byte 1, din[7]=0: stop strobe, stop[i]=din[3+i] for i<CH, pulsed for 1 cycle.
- Decoder, byte 2: mask=din[7:4] & ((1<<CH)-1), att=din[3:0]. Push {phrase, mask, att} one cycle after wr_ev.
  - If mask==0 the request is discarded and nothing is pushed.
  - If the FIFO is full the request is dropped and ovf is set to 1 (cleared only by rst).
  - Push and pop in the same cycle are both honoured.
- FSM IDLE: when the FIFO is not empty, pop the head, set rom_cs=1, idx=0 and go to FETCH.
- FSM FETCH: rom_addr={phrase, idx}.
  - After each address change, the first cycle is a settle cycle and rom_ok is ignored in it.
  - After that, the first cycle with rom_ok=1 captures rom_data into byte idx and increments idx.
  - After idx=5 is captured, go to LOAD.
  - Byte order: 0..2 are start[23:0] big-endian, 3..5 are stop[23:0]; the low AW bits are kept.
- FSM LOAD (1 cycle):
  - start=mask & ~busy is registered into the strobe output for the next cycle. Channels still busy are not restarted, which matches the MSM6295.
  - start_addr, stop_addr and att are registered in the same cycle.
  - rom_cs=0, then return to IDLE.
  - The strobe and data are coincident in the cycle after LOAD.
- Latency: rom_ok tied to 1 gives 6×2 fetch cycles + 1 LOAD cycle. From pop to the start strobe is 14 cycles.
- Back-to-back queued requests: IDLE re-pops on the cycle after LOAD, with rom_cs low for 1 cycle between fetches.
- Stop and start on the same channel in the same cycle: both strobes are asserted; the channel engine gives stop priority.
- A stop for a channel whose request is still queued does not cancel the queued request.
- A byte-2 write arriving while the FSM is fetching is queued and never corrupts the fetch in progress.

Decomposition:
- Package jt6295_pkg: ST_IDLE/ST_FETCH/ST_LOAD encodings, TBL_BYTES=6, and the command bit-position constants (CMD_START_BIT=7, STOP_LSB=3, MASK_LSB=4).
- Sub-module jt6295_reqfifo: a synchronous FIFO, QD entries × (PHW+CH+4) bits, with push, pop, full and empty.

Test Plan:
- rom_ok=1, write 0x83 then 0x14 with busy=0, table entry 3 = 00 12 34 00 56 78. Required: exactly one start=0001 strobe, start_addr=0x01234, stop_addr=0x05678, att=4, 14 cycles after the pop.
- Write 0x78, i.e. stop mask din[6:3]=1111. Required: stop=1111 for exactly 1 cycle; no ROM activity.
- QD=2: three 2-byte starts written during one fetch with rom_ok slowed to 1-in-4 cycles. Required: two served in FIFO order, the third dropped, ovf=1.
- busy=0010 and a start with mask 0011. Required: start=0001 only.
- AW=24, table entry bytes AB CD EF. Required: start_addr=0xABCDEF. AW=18: start_addr=0x3CDEF.
- Assert rst during FETCH idx=3. Required: the next cycle has rom_cs=0 and start=0 with the FIFO empty; a following command is fetched normally from idx 0.
